vme_write_engine: RTL

VME_WRITE_ENGINE -- requirements
Module: vme_write_engine

---
 rtl/vta_vme_pkg.sv | 15 +
 rtl/vme_write_engine.sv | 102 ++++++++++
 2 files changed

// File: rtl/vta_vme_pkg.sv
// Shared definitions for the VME write path: state encoding and default widths.
package vta_vme_pkg;

    localparam int VME_ADDR_W = 32;
    localparam int VME_DATA_W = 64;
    localparam int VME_LEN_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } vme_state_e;

endpackage

// File: rtl/vme_write_engine.sv
// Single-burst AXI write engine: latches a command, issues AW, streams caller
// beats straight through to W, then waits for the B response.
module vme_write_engine
    import vta_vme_pkg::*;
#(
    parameter int ADDR_W = VME_ADDR_W,
    parameter int DATA_W = VME_DATA_W,
    parameter int LEN_W  = VME_LEN_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              mem_aw_valid,
    input  logic              mem_aw_ready,
    output logic [ADDR_W-1:0] mem_aw_bits_addr,
    output logic [LEN_W-1:0]  mem_aw_bits_len,
    output logic              mem_w_valid,
    input  logic              mem_w_ready,
    output logic [DATA_W-1:0] mem_w_bits_data,
    output logic              mem_w_bits_last,
    input  logic              mem_b_valid,
    output logic              mem_b_ready,
    output logic              busy,
    output logic              done
);

    vme_state_e        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_done;

    logic w_in_w;
    logic w_last;
    logic w_w_fire;

    assign w_in_w   = (r_state == ST_W);
    assign w_last   = w_in_w && (r_cnt == r_len);
    assign w_w_fire = w_in_w && wr_valid && mem_w_ready;

    // The counter wraps only on the final beat of a max-length burst, after last is seen.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_addr  <= cmd_addr;
                        r_len   <= cmd_len;
                        r_cnt   <= '0;
                        r_state <= ST_AW;
                    end
                end
                ST_AW: begin
                    if (mem_aw_ready) begin
                        r_state <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_w_fire) begin
                        r_cnt <= r_cnt + LEN_W'(1);
                        if (w_last) begin
                            r_state <= ST_B;
                        end
                    end
                end
                ST_B: begin
                    if (mem_b_valid) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready        = (r_state == ST_IDLE) && reset;
    assign busy             = (r_state != ST_IDLE);
    assign done             = r_done;
    assign mem_aw_valid     = (r_state == ST_AW);
    assign mem_aw_bits_addr = r_addr;
    assign mem_aw_bits_len  = r_len;
    assign mem_w_valid      = w_in_w && wr_valid;
    assign wr_ready         = w_in_w && mem_w_ready;
    assign mem_w_bits_data  = wr_data;
    assign mem_w_bits_last  = w_last;
    assign mem_b_ready      = (r_state == ST_B);

endmodule
